// File: rtl/r_ctrl.sv
// -----------------------------------------------------------------------------
// r_ctrl -- ingress controller for the 1x4 router.
//
// Moves one packet at a time from the input port into one of four r_fifo
// instances. The destination is taken from bits [1:0] of the header byte
// ({len[7:2], addr[1:0]}). The controller drives the per-FIFO write enables and
// the state strobes used by the input register/parity block. One read-timeout
// timer per output port generates that FIFO's soft_reset flush pulse.
//
// Ports
//   clk            rising-edge clock
//   resetn         synchronous active-low reset
//   pkt_valid      high for header and payload bytes, low on the parity byte
//   data_in        input byte; [1:0] is the destination when it is a header
//   fifo_full      full flags from r_fifo[i]
//   fifo_empty     empty flags from r_fifo[i]
//   read_enb       downstream read strobes, one per FIFO
//   parity_done    register block has captured the parity byte
//   low_pkt_valid  pkt_valid fell while the FSM was stalled on a full FIFO
//   write_enb      one-hot write enable to r_fifo[addr]
//   soft_reset     one-cycle flush pulse to r_fifo[i]
//   valid_out      ~fifo_empty[i] (combinational)
//   busy           source must hold data_in
//   detect_add .. rst_int_reg   state decodes for the register block / FIFOs
// -----------------------------------------------------------------------------
module r_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PORTS  = 4,
  parameter int TIMEOUT    = 30,
  parameter int TMR_W      = 5
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  pkt_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [NUM_PORTS-1:0]  fifo_full,
  input  logic [NUM_PORTS-1:0]  fifo_empty,
  input  logic [NUM_PORTS-1:0]  read_enb,
  input  logic                  parity_done,
  input  logic                  low_pkt_valid,
  output logic [NUM_PORTS-1:0]  write_enb,
  output logic [NUM_PORTS-1:0]  soft_reset,
  output logic [NUM_PORTS-1:0]  valid_out,
  output logic                  busy,
  output logic                  detect_add,
  output logic                  lfd_state,
  output logic                  ld_state,
  output logic                  laf_state,
  output logic                  full_state,
  output logic                  rst_int_reg
);

  // The port address is two bits wide; the router has exactly four FIFOs.
  localparam int ADDR_W = 2;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL          = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   hdr_addr;
  logic                wr;

  // Only the address field of the header matters here; the length field is
  // consumed by the register block.
  logic unused_hdr_len;
  assign unused_hdr_len = ^data_in[DATA_WIDTH-1:ADDR_W];

  assign hdr_addr  = data_in[ADDR_W-1:0];
  assign valid_out = ~fifo_empty;

  // ---------------------------------------------------------------------------
  // Read-timeout timers, one per port, independent of the FSM. A timer counts
  // consecutive cycles in which its FIFO holds data that nobody reads. On the
  // TIMEOUT-th such cycle it pulses soft_reset and starts over.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_timer
      logic [TMR_W-1:0] timer_q, timer_d;
      logic             fire;

      always_comb begin
        timer_d = timer_q;
        fire    = 1'b0;
        if (read_enb[gi] || !valid_out[gi]) begin
          timer_d = '0;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          fire    = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (!resetn) begin
          timer_q <= '0;
        end else begin
          timer_q <= timer_d;
        end
      end

      assign soft_reset[gi] = fire;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Packet sequencing FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;

    unique case (state_q)
      DECODE_ADDRESS: begin
        if (pkt_valid) begin
          // The destination is latched only when the packet is accepted, so
          // every later state indexes the FIFO the header selected.
          addr_d  = hdr_addr;
          state_d = fifo_empty[hdr_addr] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: begin
        state_d = LOAD_DATA;
      end
      LOAD_DATA: begin
        // Leave on the same cycle full is seen so FIFO_FULL never writes.
        if (fifo_full[addr_q]) begin
          state_d = FIFO_FULL;
        end else if (!pkt_valid) begin
          state_d = LOAD_PARITY;
        end
      end
      FIFO_FULL: begin
        if (!fifo_full[addr_q]) begin
          state_d = LOAD_AFTER_FULL;
        end
      end
      LOAD_AFTER_FULL: begin
        if (parity_done) begin
          state_d = DECODE_ADDRESS;
        end else if (low_pkt_valid) begin
          state_d = LOAD_PARITY;
        end else begin
          state_d = LOAD_DATA;
        end
      end
      LOAD_PARITY: begin
        state_d = CHECK_PARITY_ERROR;
      end
      CHECK_PARITY_ERROR: begin
        state_d = fifo_full[addr_q] ? FIFO_FULL : DECODE_ADDRESS;
      end
      WAIT_TILL_EMPTY: begin
        if (fifo_empty[addr_q]) begin
          state_d = LOAD_FIRST_DATA;
        end
      end
      default: begin
        state_d = DECODE_ADDRESS;
      end
    endcase

    // A flush of the destination FIFO abandons the packet in progress,
    // whatever the state would otherwise have done.
    if (state_q != DECODE_ADDRESS && soft_reset[addr_q]) begin
      state_d = DECODE_ADDRESS;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Moore outputs decoded from the current state
  // ---------------------------------------------------------------------------
  always_comb begin
    busy        = 1'b0;
    wr          = 1'b0;
    detect_add  = 1'b0;
    lfd_state   = 1'b0;
    ld_state    = 1'b0;
    laf_state   = 1'b0;
    full_state  = 1'b0;
    rst_int_reg = 1'b0;

    unique case (state_q)
      DECODE_ADDRESS: begin
        detect_add = 1'b1;
      end
      LOAD_FIRST_DATA: begin
        busy      = 1'b1;
        wr        = 1'b1;
        lfd_state = 1'b1;
      end
      LOAD_DATA: begin
        wr       = 1'b1;
        ld_state = 1'b1;
      end
      FIFO_FULL: begin
        busy       = 1'b1;
        full_state = 1'b1;
      end
      LOAD_AFTER_FULL: begin
        busy      = 1'b1;
        wr        = 1'b1;
        laf_state = 1'b1;
      end
      LOAD_PARITY: begin
        busy = 1'b1;
        wr   = 1'b1;
      end
      CHECK_PARITY_ERROR: begin
        busy        = 1'b1;
        rst_int_reg = 1'b1;
      end
      WAIT_TILL_EMPTY: begin
        busy = 1'b1;
      end
      default: begin
        detect_add = 1'b1;
      end
    endcase
  end

  assign write_enb = wr ? (NUM_PORTS'(1) << addr_q) : '0;

endmodule

// File: tb/tb_r_ctrl.sv
// -----------------------------------------------------------------------------
// tb_r_ctrl -- self-checking bench for r_ctrl.
// Each scenario task drives one cycle at a time, pushes the expected output
// vector into a scoreboard queue, and pops/compares it on the falling edge.
// Observed vector layout:
//   {write_enb[3:0], soft_reset[3:0], valid_out[3:0],
//    busy, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg}
// -----------------------------------------------------------------------------
module tb_r_ctrl;

  localparam int S_DA  = 0;
  localparam int S_LFD = 1;
  localparam int S_LD  = 2;
  localparam int S_FF  = 3;
  localparam int S_LAF = 4;
  localparam int S_LP  = 5;
  localparam int S_CPE = 6;
  localparam int S_WTE = 7;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [3:0] fifo_full;
  logic [3:0] fifo_empty;
  logic [3:0] read_enb;
  logic       parity_done;
  logic       low_pkt_valid;
  logic [3:0] write_enb;
  logic [3:0] soft_reset;
  logic [3:0] valid_out;
  logic       busy;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       rst_int_reg;

  int tests = 0;
  int fails = 0;

  logic [18:0] sb[$];
  logic [18:0] obs;
  logic [18:0] e;

  always #5 clk = ~clk;

  r_ctrl dut (
    .clk           (clk),
    .resetn        (resetn),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .read_enb      (read_enb),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .write_enb     (write_enb),
    .soft_reset    (soft_reset),
    .valid_out     (valid_out),
    .busy          (busy),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .rst_int_reg   (rst_int_reg)
  );

  assign obs = {write_enb, soft_reset, valid_out, busy, detect_add,
                lfd_state, ld_state, laf_state, full_state, rst_int_reg};

  // Expected outputs for a given state, written from the state table.
  // Strobe order: busy, detect_add, lfd, ld, laf, full, rst_int_reg.
  function automatic logic [18:0] exp_out(input int st, input logic [1:0] ad,
                                          input logic [3:0] sr, input logic [3:0] vo);
    logic [6:0] d;
    logic       w;
    w = 1'b0;
    case (st)
      S_DA:    d = 7'b0100000;
      S_LFD:   begin d = 7'b1010000; w = 1'b1; end
      S_LD:    begin d = 7'b0001000; w = 1'b1; end
      S_FF:    d = 7'b1000010;
      S_LAF:   begin d = 7'b1000100; w = 1'b1; end
      S_LP:    begin d = 7'b1000000; w = 1'b1; end
      S_CPE:   d = 7'b1000001;
      default: d = 7'b1000000;   // WTE
    endcase
    return {(w ? (4'b0001 << ad) : 4'b0000), sr, vo, d};
  endfunction

  task automatic drive(input logic pv, input logic [7:0] d, input logic [3:0] ff,
                       input logic [3:0] fe, input logic [3:0] re,
                       input logic pd, input logic lpv);
    pkt_valid     = pv;
    data_in       = d;
    fifo_full     = ff;
    fifo_empty    = fe;
    read_enb      = re;
    parity_done   = pd;
    low_pkt_valid = lpv;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    drive(1'b0, 8'h00, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    for (int c = 0; c < 2; c++) begin
      sb.push_back(exp_out(S_DA, 2'd0, 4'h0, ~fifo_empty));
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL reset cyc %0d: got %b want %b", c, obs, e);
      end else $display("[TB] reset cyc %0d ok %b", c, obs);
      @(posedge clk); #1;
    end
    resetn = 1'b1;
  endtask

  task automatic test_normal();
    int st;
    for (int c = 0; c < 8; c++) begin
      case (c)
        0: begin drive(1, 8'h0E, 0, 4'hF, 0, 0, 0); st = S_DA;  end
        1: begin drive(1, 8'h11, 0, 4'hF, 0, 0, 0); st = S_LFD; end
        2: begin drive(1, 8'h22, 0, 4'hF, 0, 0, 0); st = S_LD;  end
        3: begin drive(1, 8'h33, 0, 4'hF, 0, 0, 0); st = S_LD;  end
        4: begin drive(0, 8'h5A, 0, 4'hF, 0, 0, 0); st = S_LD;  end
        5: begin drive(0, 8'h00, 0, 4'hF, 0, 0, 0); st = S_LP;  end
        6: begin drive(0, 8'h00, 0, 4'hF, 0, 0, 0); st = S_CPE; end
        default: begin drive(0, 8'h00, 0, 4'hF, 0, 0, 0); st = S_DA; end
      endcase
      sb.push_back(exp_out(st, 2'd2, 4'h0, ~fifo_empty));
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL normal cyc %0d: got %b want %b", c, obs, e);
      end else $display("[TB] normal cyc %0d ok %b", c, obs);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_busy_dest();
    int st;
    for (int c = 0; c < 8; c++) begin
      case (c)
        0: begin drive(1, 8'h05, 0, 4'hD, 0, 0, 0); st = S_DA;  end
        1: begin drive(1, 8'h05, 0, 4'hD, 0, 0, 0); st = S_WTE; end
        2: begin drive(1, 8'h05, 0, 4'hF, 0, 0, 0); st = S_WTE; end
        3: begin drive(0, 8'h44, 0, 4'hF, 0, 0, 0); st = S_LFD; end
        4: begin drive(0, 8'h00, 0, 4'hF, 0, 0, 0); st = S_LD;  end
        5: begin drive(0, 8'h00, 0, 4'hF, 0, 0, 0); st = S_LP;  end
        6: begin drive(0, 8'h00, 0, 4'hF, 0, 0, 0); st = S_CPE; end
        default: begin drive(0, 8'h00, 0, 4'hF, 0, 0, 0); st = S_DA; end
      endcase
      sb.push_back(exp_out(st, 2'd1, 4'h0, ~fifo_empty));
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL busy_dest cyc %0d: got %b want %b", c, obs, e);
      end else $display("[TB] busy_dest cyc %0d ok %b", c, obs);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_full_stall();
    int st;
    for (int c = 0; c < 9; c++) begin
      case (c)
        0: begin drive(1, 8'h0C, 4'h0, 4'hF, 0, 0, 0); st = S_DA;  end
        1: begin drive(1, 8'h01, 4'h0, 4'hF, 0, 0, 0); st = S_LFD; end
        2: begin drive(1, 8'h02, 4'h1, 4'hF, 0, 0, 0); st = S_LD;  end
        3: begin drive(1, 8'h02, 4'h1, 4'hF, 0, 0, 0); st = S_FF;  end
        4: begin drive(1, 8'h02, 4'h0, 4'hF, 0, 0, 0); st = S_FF;  end
        5: begin drive(0, 8'h03, 4'h0, 4'hF, 0, 0, 1); st = S_LAF; end
        6: begin drive(0, 8'h00, 4'h0, 4'hF, 0, 0, 0); st = S_LP;  end
        7: begin drive(0, 8'h00, 4'h0, 4'hF, 0, 0, 0); st = S_CPE; end
        default: begin drive(0, 8'h00, 4'h0, 4'hF, 0, 0, 0); st = S_DA; end
      endcase
      sb.push_back(exp_out(st, 2'd0, 4'h0, ~fifo_empty));
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL full_stall cyc %0d: got %b want %b", c, obs, e);
      end else $display("[TB] full_stall cyc %0d ok %b", c, obs);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    int         st;
    logic [1:0] ad;
    for (int c = 0; c < 14; c++) begin
      ad = (c < 7) ? 2'd3 : 2'd2;
      case (c)
        0:  begin drive(1, 8'h07, 4'h0, 4'hF, 0, 0, 0); st = S_DA;  end
        1:  begin drive(1, 8'h08, 4'h0, 4'hF, 0, 0, 0); st = S_LFD; end
        2:  begin drive(0, 8'h09, 4'h0, 4'hF, 0, 0, 0); st = S_LD;  end
        3:  begin drive(0, 8'h00, 4'h0, 4'hF, 0, 0, 0); st = S_LP;  end
        4:  begin drive(0, 8'h00, 4'h8, 4'hF, 0, 0, 0); st = S_CPE; end
        5:  begin drive(0, 8'h00, 4'h0, 4'hF, 0, 0, 0); st = S_FF;  end
        6:  begin drive(0, 8'h00, 4'h0, 4'hF, 0, 1, 0); st = S_LAF; end
        7:  begin drive(1, 8'h0A, 4'h0, 4'hF, 0, 0, 0); st = S_DA;  end
        8:  begin drive(1, 8'h0B, 4'h0, 4'hF, 0, 0, 0); st = S_LFD; end
        9:  begin drive(1, 8'h0C, 4'h0, 4'hF, 0, 0, 0); st = S_LD;  end
        10: begin drive(0, 8'h0D, 4'h0, 4'hF, 0, 0, 0); st = S_LD;  end
        11: begin drive(0, 8'h00, 4'h0, 4'hF, 0, 0, 0); st = S_LP;  end
        12: begin drive(0, 8'h00, 4'h0, 4'hF, 0, 0, 0); st = S_CPE; end
        default: begin drive(0, 8'h00, 4'h0, 4'hF, 0, 0, 0); st = S_DA; end
      endcase
      sb.push_back(exp_out(st, ad, 4'h0, ~fifo_empty));
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL back_to_back cyc %0d: got %b want %b", c, obs, e);
      end else $display("[TB] back_to_back cyc %0d ok %b", c, obs);
      @(posedge clk); #1;
    end
  endtask

  // Port 3 holds data with nobody reading: pulse on the 30th unread cycle.
  // Second pass reads on cycle 29, which must suppress the pulse.
  task automatic test_timeout();
    logic [3:0] sr;
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 1; k <= 31; k++) begin
        drive(0, 8'h00, 4'h0, 4'h7, ((pass == 1 && k == 29) ? 4'h8 : 4'h0), 0, 0);
        sr = (pass == 0 && k == 30) ? 4'h8 : 4'h0;
        sb.push_back(exp_out(S_DA, 2'd0, sr, ~fifo_empty));
        @(negedge clk);
        e = sb.pop_front();
        tests++;
        if (obs !== e) begin
          fails++;
          $display("FAIL timeout pass %0d cyc %0d: got %b want %b", pass, k, obs, e);
        end else $display("[TB] timeout pass %0d cyc %0d ok %b", pass, k, obs);
        @(posedge clk); #1;
      end
      // One cycle with the FIFO empty clears the timer between passes.
      drive(0, 8'h00, 4'h0, 4'hF, 4'h0, 0, 0);
      sb.push_back(exp_out(S_DA, 2'd0, 4'h0, ~fifo_empty));
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL timeout clear pass %0d: got %b want %b", pass, obs, e);
      end else $display("[TB] timeout clear pass %0d ok %b", pass, obs);
      @(posedge clk); #1;
    end
  endtask

  // Destination FIFO 1 times out while the FSM sits in LD: abandon to DA.
  task automatic test_soft_reset_mid();
    int         st;
    logic [3:0] sr;
    for (int c = 0; c < 34; c++) begin
      sr = 4'h0;
      if (c == 0) begin
        drive(1, 8'h0D, 4'h0, 4'hF, 0, 0, 0); st = S_DA;
      end else if (c == 1) begin
        drive(1, 8'h10, 4'h0, 4'hF, 0, 0, 0); st = S_LFD;
      end else if (c <= 31) begin
        drive(1, 8'h20, 4'h0, 4'hD, 0, 0, 0); st = S_LD;
        if (c == 31) sr = 4'h2;
      end else begin
        drive(0, 8'h00, 4'h0, 4'hF, 0, 0, 0); st = S_DA;
      end
      sb.push_back(exp_out(st, 2'd1, sr, ~fifo_empty));
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL soft_reset_mid cyc %0d: got %b want %b", c, obs, e);
      end else $display("[TB] soft_reset_mid cyc %0d ok %b", c, obs);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_busy_dest();
    test_full_stall();
    test_back_to_back();
    test_timeout();
    test_soft_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
